cfg_regbank: RTL and testbench



---
 rtl/cfg_regbank_pkg.sv | 33 +++
 rtl/cfg_regbank_cnt.sv | 54 +++++
 rtl/cfg_regbank.sv | 213 +++++++++++++++++++++
 tb/tb_cfg_regbank.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_regbank_pkg.sv
// Shared definitions for the configuration/status register bank:
// address regions, system-region offsets, CTRL layout and the unmapped read value.
package cfg_regbank_pkg;

    // addr[7:6] selects one of four regions
    typedef enum logic [1:0] {
        REGION_SYS = 2'd0,
        REGION_RW  = 2'd1,
        REGION_RO  = 2'd2,
        REGION_CNT = 2'd3
    } region_e;

    // System-region word offsets
    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_SNAP     = 6'h01;
    localparam logic [5:0] OFF_STICKY   = 6'h02;
    localparam logic [5:0] OFF_IRQ_MASK = 6'h03;

    // CTRL register layout, LSB first: bit0 cnt_en, bit1 clr_on_rd,
    // bit2 snap_mode, bit3 saturate
    typedef struct packed {
        logic saturate;
        logic snap_mode;
        logic clr_on_rd;
        logic cnt_en;
    } ctrl_t;

    localparam int CTRL_WIDTH = $bits(ctrl_t);

    // Returned for any offset that maps to nothing
    localparam logic [31:0] PKG_DEFAULT_RDATA = 32'hF0F0_F0F0;

endpackage

// File: rtl/cfg_regbank_cnt.sv
// One event-counter channel: live counter with wrap or saturate,
// a snapshot shadow, and clear-on-read that still counts the event of the clearing cycle.
module cfg_cnt_chan
    import cfg_regbank_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_evt,
    input  logic                 i_cnt_en,
    input  logic                 i_saturate,
    input  logic                 i_clr,
    input  logic                 i_snap,
    output logic [CNT_WIDTH-1:0] o_live,
    output logic [CNT_WIDTH-1:0] o_shadow
);

    logic [CNT_WIDTH-1:0] r_live;
    logic [CNT_WIDTH-1:0] r_shadow;
    logic                 w_inc;
    logic                 w_at_max;
    logic [CNT_WIDTH-1:0] w_next;

    assign w_inc    = i_evt & i_cnt_en;
    assign w_at_max = &r_live;

    // Next live value: a clear reloads with this cycle's event so nothing is lost
    always_comb begin
        w_next = r_live;
        if (i_clr) begin
            w_next = CNT_WIDTH'(w_inc);
        end else if (w_inc && !(i_saturate && w_at_max)) begin
            w_next = r_live + CNT_WIDTH'(1);
        end
    end

    // Live counter and shadow; the shadow captures the pre-edge live value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_live   <= '0;
            r_shadow <= '0;
        end else begin
            r_live <= w_next;
            if (i_snap) begin
                r_shadow <= r_live;
            end
        end
    end

    assign o_live   = r_live;
    assign o_shadow = r_shadow;

endmodule

// File: rtl/cfg_regbank.sv
// Configuration/status register bank: RW control words with byte strobes,
// live RO status words, event counters and a W1C sticky interrupt with mask.
// Host access: wr and rd are single-cycle strobes with no back-pressure; every
// rd in cycle T is answered by a one-cycle rdata_vld pulse in cycle T+2, one
// read may be issued per cycle, and rdata holds between pulses.
module cfg_regbank
    import cfg_regbank_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RW     = 8,
    parameter int NUM_RO     = 4,
    parameter int NUM_CNT    = 4,
    parameter int NUM_IRQ    = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA = DATA_WIDTH'(PKG_DEFAULT_RDATA),
    // Counter width; narrower than DATA_WIDTH reads back zero-extended
    parameter int CNT_WIDTH  = DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic                         wr,
    input  logic                         rd,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic                         rdata_vld,
    output logic [NUM_RW*DATA_WIDTH-1:0] rw_regs,
    input  logic [NUM_RO*DATA_WIDTH-1:0] ro_regs,
    input  logic [NUM_CNT-1:0]           cnt_evt,
    input  logic [NUM_IRQ-1:0]           irq_src,
    output logic                         irq
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    // Request-side decode
    region_e              w_region;
    logic [5:0]           w_offset;
    logic                 w_sys_wr;
    logic                 w_wr_ctrl;
    logic                 w_wr_sticky;
    logic                 w_wr_mask;
    logic                 w_snap;
    logic                 w_unused_addr;

    // Architectural state
    ctrl_t                r_ctrl;
    logic [NUM_IRQ-1:0]   r_sticky;
    logic [NUM_IRQ-1:0]   r_mask;
    logic                 r_irq;
    logic [DATA_WIDTH-1:0] r_rw [NUM_RW];

    // Counter channels
    logic [CNT_WIDTH-1:0] w_live   [NUM_CNT];
    logic [CNT_WIDTH-1:0] w_shadow [NUM_CNT];
    logic [NUM_CNT-1:0]   w_cnt_rd;
    logic [CNT_WIDTH-1:0] w_cnt_sel;

    // Read pipeline
    logic                 r_s1_vld;
    logic [7:0]           r_s1_addr;
    logic [CNT_WIDTH-1:0] r_s1_cnt;
    region_e              w_s1_region;
    logic [5:0]           w_s1_off;
    logic [DATA_WIDTH-1:0] w_rd_mux;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                 r_rdata_vld;

    assign w_region      = region_e'(addr[7:6]);
    assign w_offset      = addr[5:0];
    assign w_unused_addr = ^addr[ADDR_WIDTH-1:8];

    assign w_sys_wr    = wr && (w_region == REGION_SYS);
    assign w_wr_ctrl   = w_sys_wr && (w_offset == OFF_CTRL);
    assign w_wr_sticky = w_sys_wr && (w_offset == OFF_STICKY);
    assign w_wr_mask   = w_sys_wr && (w_offset == OFF_IRQ_MASK);
    assign w_snap      = w_sys_wr && (w_offset == OFF_SNAP) && wdata[0];

    // Host-visible control state, sticky interrupts and the RW register file
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ctrl   <= '0;
            r_mask   <= '0;
            r_sticky <= '0;
            r_irq    <= 1'b0;
            for (int i = 0; i < NUM_RW; i++) begin
                r_rw[i] <= '0;
            end
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= ctrl_t'(wdata[CTRL_WIDTH-1:0]);
            end
            if (w_wr_mask) begin
                r_mask <= wdata[NUM_IRQ-1:0];
            end
            // a set arriving in the same cycle as its W1C wins
            r_sticky <= (w_wr_sticky ? (r_sticky & ~wdata[NUM_IRQ-1:0]) : r_sticky) | irq_src;
            r_irq    <= |(r_sticky & r_mask);
            if (wr && (w_region == REGION_RW)) begin
                for (int i = 0; i < NUM_RW; i++) begin
                    for (int b = 0; b < NUM_BYTES; b++) begin
                        if ((w_offset == 6'(i)) && wstrb[b]) begin
                            r_rw[i][b*8 +: 8] <= wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    generate
        for (genvar c = 0; c < NUM_CNT; c++) begin : g_cnt
            assign w_cnt_rd[c] = rd && (w_region == REGION_CNT) && (w_offset == 6'(c));

            cfg_cnt_chan #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_chan (
                .clk        (clk),
                .rstn       (rstn),
                .i_evt      (cnt_evt[c]),
                .i_cnt_en   (r_ctrl.cnt_en),
                .i_saturate (r_ctrl.saturate),
                .i_clr      (w_cnt_rd[c] && r_ctrl.clr_on_rd),
                .i_snap     (w_snap),
                .o_live     (w_live[c]),
                .o_shadow   (w_shadow[c])
            );
        end

        for (genvar i = 0; i < NUM_RW; i++) begin : g_rw_out
            assign rw_regs[i*DATA_WIDTH +: DATA_WIDTH] = r_rw[i];
        end
    endgenerate

    // Counter value seen by a read: taken at the request edge, before any clear
    always_comb begin
        w_cnt_sel = '0;
        for (int c = 0; c < NUM_CNT; c++) begin
            if (w_cnt_rd[c]) begin
                w_cnt_sel = r_ctrl.snap_mode ? w_shadow[c] : w_live[c];
            end
        end
    end

    assign w_s1_region = region_e'(r_s1_addr[7:6]);
    assign w_s1_off    = r_s1_addr[5:0];

    // Second-stage decode: registers are sampled one cycle after the request,
    // so a write in the request cycle is already visible
    always_comb begin
        w_rd_mux = DEFAULT_RDATA;
        case (w_s1_region)
            REGION_SYS: begin
                case (w_s1_off)
                    OFF_CTRL:     w_rd_mux = DATA_WIDTH'(r_ctrl);
                    OFF_SNAP:     w_rd_mux = '0;
                    OFF_STICKY:   w_rd_mux = DATA_WIDTH'(r_sticky);
                    OFF_IRQ_MASK: w_rd_mux = DATA_WIDTH'(r_mask);
                    default:      w_rd_mux = DEFAULT_RDATA;
                endcase
            end
            REGION_RW: begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (w_s1_off == 6'(i)) begin
                        w_rd_mux = r_rw[i];
                    end
                end
            end
            REGION_RO: begin
                for (int i = 0; i < NUM_RO; i++) begin
                    if (w_s1_off == 6'(i)) begin
                        w_rd_mux = ro_regs[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            REGION_CNT: begin
                for (int c = 0; c < NUM_CNT; c++) begin
                    if (w_s1_off == 6'(c)) begin
                        w_rd_mux = DATA_WIDTH'(r_s1_cnt);
                    end
                end
            end
            default: w_rd_mux = DEFAULT_RDATA;
        endcase
    end

    // Two-stage read pipeline; reset drops any read in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vld    <= 1'b0;
            r_s1_addr   <= '0;
            r_s1_cnt    <= '0;
            r_rdata     <= '0;
            r_rdata_vld <= 1'b0;
        end else begin
            r_s1_vld <= rd;
            if (rd) begin
                r_s1_addr <= addr[7:0];
                r_s1_cnt  <= w_cnt_sel;
            end
            r_rdata_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign rdata     = r_rdata;
    assign rdata_vld = r_rdata_vld;
    assign irq       = r_irq;

endmodule

// File: tb/tb_cfg_regbank.sv
// Bench for cfg_regbank: a behavioural model of the register map is stepped on
// every clock edge and compared against the DUT on every falling edge, with
// directed sequences that pin known literal values and a randomized phase.
module tb_cfg_regbank;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NRW  = 8;
    localparam int NRO  = 4;
    localparam int NCNT = 4;
    localparam int NIRQ = 8;
    localparam int CW   = 8;
    localparam logic [31:0] DEF = 32'hF0F0_F0F0;

    logic               clk;
    logic               rstn;
    logic [AW-1:0]      addr;
    logic [DW-1:0]      wdata;
    logic [DW/8-1:0]    wstrb;
    logic               wr;
    logic               rd;
    logic [DW-1:0]      rdata;
    logic               rdata_vld;
    logic [NRW*DW-1:0]  rw_regs;
    logic [NRO*DW-1:0]  ro_regs;
    logic [NCNT-1:0]    cnt_evt;
    logic [NIRQ-1:0]    irq_src;
    logic               irq;

    cfg_regbank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_RW     (NRW),
        .NUM_RO     (NRO),
        .NUM_CNT    (NCNT),
        .NUM_IRQ    (NIRQ),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .addr      (addr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wr        (wr),
        .rd        (rd),
        .rdata     (rdata),
        .rdata_vld (rdata_vld),
        .rw_regs   (rw_regs),
        .ro_regs   (ro_regs),
        .cnt_evt   (cnt_evt),
        .irq_src   (irq_src),
        .irq       (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_rw [NRW];
    logic [3:0]  m_ctrl;
    logic [7:0]  m_mask;
    logic [7:0]  m_sticky;
    logic        m_irq;
    logic [7:0]  m_cnt [NCNT];
    logic [7:0]  m_shd [NCNT];
    logic [31:0] m_hold;
    bit          p_vld;
    logic [7:0]  p_addr;
    logic [7:0]  p_cnt;
    logic [DW-1:0] exp_q[$];

    function automatic logic [31:0] model_read(input logic [7:0] a, input logic [7:0] cval);
        int rg;
        int of;
        rg = int'(a) / 64;
        of = int'(a) % 64;
        if (rg == 0) begin
            if (of == 0) return {28'b0, m_ctrl};
            if (of == 1) return 32'h0;
            if (of == 2) return {24'b0, m_sticky};
            if (of == 3) return {24'b0, m_mask};
        end else if (rg == 1) begin
            if (of < NRW) return m_rw[of];
        end else if (rg == 2) begin
            if (of < NRO) return ro_regs[of*32 +: 32];
        end else begin
            if (of < NCNT) return {24'b0, cval};
        end
        return DEF;
    endfunction

    always @(posedge clk or negedge rstn) begin : model_blk
        int rg;
        int of;
        bit snap_now;
        bit inc;
        bit clr;
        logic [7:0] ns;
        if (!rstn) begin
            for (int i = 0; i < NRW; i++) m_rw[i] = '0;
            for (int c = 0; c < NCNT; c++) begin
                m_cnt[c] = '0;
                m_shd[c] = '0;
            end
            m_ctrl = '0; m_mask = '0; m_sticky = '0; m_irq = 1'b0; m_hold = '0;
            p_vld = 1'b0; p_addr = '0; p_cnt = '0;
            exp_q.delete();
        end else begin
            // a read requested last cycle is answered from the state before this edge
            if (p_vld) begin
                m_hold = model_read(p_addr, p_cnt);
                exp_q.push_back(m_hold);
            end
            rg = int'(addr[7:0]) / 64;
            of = int'(addr[7:0]) % 64;
            p_vld = rd;
            if (rd) begin
                p_addr = addr[7:0];
                p_cnt  = '0;
                if (rg == 3 && of < NCNT) p_cnt = m_ctrl[2] ? m_shd[of] : m_cnt[of];
            end
            m_irq = |(m_sticky & m_mask);
            snap_now = wr && rg == 0 && of == 1 && wdata[0];
            for (int c = 0; c < NCNT; c++) begin
                inc = cnt_evt[c] && m_ctrl[0];
                clr = rd && rg == 3 && of == c && m_ctrl[1];
                if (snap_now) m_shd[c] = m_cnt[c];
                if (clr) m_cnt[c] = inc ? 8'd1 : 8'd0;
                else if (inc && !(m_ctrl[3] && m_cnt[c] == 8'hFF))
                    m_cnt[c] = 8'((int'(m_cnt[c]) + 1) % 256);
            end
            ns = m_sticky;
            if (wr && rg == 0 && of == 2) ns = ns & ~wdata[7:0];
            m_sticky = ns | irq_src;
            if (wr && rg == 0 && of == 0) m_ctrl = wdata[3:0];
            if (wr && rg == 0 && of == 3) m_mask = wdata[7:0];
            if (wr && rg == 1 && of < NRW)
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) m_rw[of][b*8 +: 8] = wdata[b*8 +: 8];
        end
    end

    // ---------------- per-cycle compare (scoreboard) ----------------
    always @(negedge clk) begin : cmp_blk
        logic [255:0] exp_rw;
        if (chk_en) begin
            for (int i = 0; i < NRW; i++) exp_rw[i*32 +: 32] = m_rw[i];
            check("rw_regs", rw_regs, exp_rw);
            check("irq", irq, m_irq);
            check("rdata_vld", rdata_vld, exp_q.size() != 0);
            check("rdata", rdata, m_hold);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    // ---------------- driver tasks (called at a falling edge, return at one) ----------------
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr = 1'b1; addr = a; wdata = d; wstrb = s;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic issue_read(input logic [31:0] a);
        rd = 1'b1; addr = a;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic wait_read(input string name, input logic [31:0] expv);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            if (rdata_vld) begin
                got = 1'b1;
                check(name, rdata, expv);
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s no rdata_vld within 4 cycles, required data=%0h", name, expv);
        end
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] expv);
        issue_read(a);
        wait_read(name, expv);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        addr = '0; wdata = '0; wstrb = '0; wr = 1'b0; rd = 1'b0;
        ro_regs = '0; cnt_evt = '0; irq_src = '0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1 chk_en = 1'b1;
        run_cycles(3);
        check("rst_rdata_vld", rdata_vld, 0);
        check("rst_rdata", rdata, 0);
        check("rst_irq", irq, 0);
        check("rst_rw_regs", rw_regs, 0);
        #2 rstn = 1'b1;
        @(negedge clk);

        // every mapped register reads 0 after reset; unmapped reads the default
        for (int i = 0; i < 4; i++) read_chk($sformatf("rst_sys%0d", i), i, 32'h0);
        for (int i = 0; i < NRW; i++) read_chk($sformatf("rst_rw%0d", i), 32'h40 + i, 32'h0);
        for (int i = 0; i < NRO; i++) read_chk($sformatf("rst_ro%0d", i), 32'h80 + i, 32'h0);
        for (int i = 0; i < NCNT; i++) read_chk($sformatf("rst_cnt%0d", i), 32'hC0 + i, 32'h0);
        read_chk("unmap_cnt5", 32'hC5, DEF);
        read_chk("unmap_sys4", 32'h04, DEF);
        read_chk("unmap_rw8", 32'h48, DEF);
        read_chk("unmap_ro4", 32'h84, DEF);

        // byte strobes; upper address bits are not decoded
        do_write(32'h0000_0040, 32'h1122_3344, 4'hF);
        do_write(32'hABCD_0040, 32'hAABB_CCDD, 4'b0101);
        check("rw0_strobe", rw_regs[31:0], 32'h11BB_33DD);
        read_chk("rw0_readback", 32'h40, 32'h11BB_33DD);
        do_write(32'h47, 32'hDEAD_BEEF, 4'hF);
        read_chk("rw7_readback", 32'h47, 32'hDEAD_BEEF);

        // clear-on-read keeps the event of the clearing cycle
        do_write(32'h00, 32'h3, 4'hF);
        cnt_evt = 4'b0010;
        run_cycles(5);
        issue_read(32'hC1);
        cnt_evt = 4'b0000;
        wait_read("cor_first", 32'd5);
        read_chk("cor_second", 32'hC1, 32'd1);
        read_chk("ctrl_readback", 32'h00, 32'h3);

        // saturation, then wrap
        do_write(32'h00, 32'h9, 4'hF);
        cnt_evt = 4'b0001;
        run_cycles(300);
        cnt_evt = 4'b0000;
        read_chk("sat_hold", 32'hC0, 32'h0000_00FF);
        do_write(32'h00, 32'h1, 4'hF);
        cnt_evt = 4'b0001;
        @(negedge clk);
        cnt_evt = 4'b0000;
        read_chk("wrap_zero", 32'hC0, 32'h0);

        // snapshot
        do_write(32'h00, 32'h5, 4'hF);
        cnt_evt = 4'b0100;
        run_cycles(7);
        cnt_evt = 4'b0000;
        do_write(32'h01, 32'h1, 4'hF);
        cnt_evt = 4'b0100;
        run_cycles(3);
        cnt_evt = 4'b0000;
        read_chk("snap_shadow", 32'hC2, 32'd7);
        read_chk("snap_reads_zero", 32'h01, 32'h0);
        do_write(32'h00, 32'h1, 4'hF);
        read_chk("snap_live", 32'hC2, 32'd10);

        // sticky interrupt with mask, set beats a simultaneous W1C
        do_write(32'h03, 32'h4, 4'hF);
        irq_src = 8'h04;
        @(negedge clk);
        irq_src = 8'h00;
        @(negedge clk);
        check("irq_set", irq, 1);
        wr = 1'b1; addr = 32'h02; wdata = 32'h4; wstrb = 4'hF; irq_src = 8'h04;
        @(negedge clk);
        wr = 1'b0; irq_src = 8'h00;
        read_chk("sticky_set_wins", 32'h02, 32'h4);
        check("irq_still_set", irq, 1);
        do_write(32'h02, 32'h4, 4'hF);
        check("irq_lag", irq, 1);
        @(negedge clk);
        check("irq_cleared", irq, 0);
        read_chk("sticky_cleared", 32'h02, 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] rgn;
            logic [5:0] off;
            rgn = 2'($urandom_range(0, 3));
            off = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : 6'($urandom_range(0, 8));
            ro_regs = {$urandom(), $urandom(), $urandom(), $urandom()};
            cnt_evt = 4'($urandom_range(0, 15));
            irq_src = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : 8'h00;
            rd      = ($urandom_range(0, 99) < 35);
            wr      = ($urandom_range(0, 99) < 30);
            addr    = {24'($urandom()), rgn, off};
            wdata   = $urandom();
            wstrb   = 4'($urandom());
            @(negedge clk);
        end
        rd = 1'b0; wr = 1'b0; cnt_evt = '0; irq_src = '0;
        run_cycles(4);

        // reset with a read in flight: no pulse afterwards
        issue_read(32'h40);
        #2 rstn = 1'b0;
        @(negedge clk);
        check("inflight_rst_vld", rdata_vld, 0);
        check("inflight_rst_rw", rw_regs, 0);
        check("inflight_rst_irq", irq, 0);
        #2 rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("inflight_dropped", rdata_vld, 0);
        end
        read_chk("post_rst_rw0", 32'h40, 32'h0);

        run_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
